// File: rtl/uart_cmd_frame_rx.sv
// UART command-frame receiver: hunts for a command byte, then writes a fixed-length
// payload into parameter RAM with stop-bit, timeout and optional checksum checking.
module uart_cmd_frame_rx #(
    parameter logic [7:0] CMD_ID       = 8'hFE,
    parameter int         NUM_PARAMS   = 32,
    parameter int         ADDR_W       = 5,
    parameter int         DIV_W        = 16,
    parameter bit         MSB_FIRST    = 1'b1,
    parameter bit         CSUM_EN      = 1'b0,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [DIV_W-1:0]  clk_per_bit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int                TO_W     = DIV_W + $clog2(TIMEOUT_BITS + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PARAMS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {FR_HUNT, FR_PARAM, FR_CSUM} fr_state_t;

    logic rx_meta_reg;
    logic rx_sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    // ---------------- byte receiver ----------------
    rx_state_t        rx_state_reg;
    logic [DIV_W-1:0] bit_cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic [7:0]       rx_byte;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] half_cnt;
    logic             bit_tick;
    logic             half_tick;
    logic             byte_valid;
    logic             byte_ferr;

    assign last_cnt   = div_reg - DIV_W'(1);
    assign half_cnt   = last_cnt >> 1;
    assign bit_tick   = (bit_cnt_reg == last_cnt);
    assign half_tick  = (bit_cnt_reg == half_cnt);
    assign shift_next = {rx_sync_reg, shift_reg[7:1]};
    assign byte_valid = (rx_state_reg == RX_STOP) && bit_tick && rx_sync_reg;
    assign byte_ferr  = (rx_state_reg == RX_STOP) && bit_tick && !rx_sync_reg;

    // Bits are always shifted in line order; the first line bit lands in shift_reg[0].
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_order
            assign rx_byte[gi] = MSB_FIRST ? shift_reg[7-gi] : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_reg <= RX_IDLE;
            bit_cnt_reg  <= '0;
            div_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        div_reg      <= clk_per_bit;
                        bit_cnt_reg  <= '0;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (half_tick) begin
                        bit_cnt_reg  <= '0;
                        bit_idx_reg  <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + DIV_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= shift_next;
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + DIV_W'(1);
                    end
                end
                RX_STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (bit_tick) begin
                        bit_cnt_reg  <= '0;
                        rx_state_reg <= RX_IDLE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + DIV_W'(1);
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- frame tracker ----------------
    fr_state_t         fr_state_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [7:0]        sum_reg;
    logic [TO_W-1:0]   gap_cnt_reg;
    logic [TO_W-1:0]   gap_limit;
    logic              gap_expired;

    assign gap_limit   = TO_W'(TIMEOUT_BITS) * TO_W'(div_reg);
    assign gap_expired = (gap_cnt_reg >= gap_limit) && (rx_state_reg == RX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            fr_state_reg <= FR_HUNT;
            index_reg    <= '0;
            sum_reg      <= '0;
            gap_cnt_reg  <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'd0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (fr_state_reg)
                FR_HUNT: begin
                    if (byte_valid && (rx_byte == CMD_ID)) begin
                        fr_state_reg <= FR_PARAM;
                        busy         <= 1'b1;
                        index_reg    <= '0;
                        sum_reg      <= '0;
                        gap_cnt_reg  <= '0;
                        err_code     <= 2'd0;
                    end
                end
                FR_PARAM, FR_CSUM: begin
                    if (byte_valid || byte_ferr) begin
                        gap_cnt_reg <= '0;
                    end else if (~&gap_cnt_reg) begin
                        gap_cnt_reg <= gap_cnt_reg + TO_W'(1);
                    end
                    if (byte_ferr) begin
                        fr_state_reg <= FR_HUNT;
                        busy         <= 1'b0;
                        frame_err    <= 1'b1;
                        err_code     <= 2'd1;
                    end else if (byte_valid) begin
                        if (fr_state_reg == FR_PARAM) begin
                            wr_en     <= 1'b1;
                            wr_addr   <= index_reg;
                            wr_data   <= rx_byte;
                            index_reg <= index_reg + ADDR_W'(1);
                            sum_reg   <= sum_reg + rx_byte;
                            if (index_reg == LAST_IDX) begin
                                if (CSUM_EN) begin
                                    fr_state_reg <= FR_CSUM;
                                end else begin
                                    fr_state_reg <= FR_HUNT;
                                    busy         <= 1'b0;
                                    frame_done   <= 1'b1;
                                end
                            end
                        end else begin
                            fr_state_reg <= FR_HUNT;
                            busy         <= 1'b0;
                            if (rx_byte == sum_reg) begin
                                frame_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd3;
                            end
                        end
                    end else if (gap_expired) begin
                        fr_state_reg <= FR_HUNT;
                        busy         <= 1'b0;
                        frame_err    <= 1'b1;
                        err_code     <= 2'd2;
                    end
                end
                default: fr_state_reg <= FR_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Bench for uart_cmd_frame_rx: three configurations (plain, checksum, MSB-first) driven
// by serialised random frames and checked against a byte-level frame model.
module tb_uart_cmd_frame_rx;

    localparam int NP = 4;
    localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

    typedef struct {
        int dut;
        int kind;
        int addr;
        int data;
        int code;
        int same;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [2:0]  rx_w;
    logic [15:0] clk_per_bit;
    wire  [2:0]  wr_en_w;
    wire  [2:0]  frame_done_w;
    wire  [2:0]  frame_err_w;
    wire  [2:0]  busy_w;
    wire  [1:0]  wr_addr_w  [3];
    wire  [7:0]  wr_data_w  [3];
    wire  [1:0]  err_code_w [3];

    int n_checks = 0;
    int n_errors = 0;
    int cpb = 16;

    ev_t        exp_q[$];
    bit         m_in   [3];
    bit         m_csum [3];
    int         m_idx  [3];
    logic [7:0] m_sum  [3];
    logic [1:0] m_err  [3];

    uart_cmd_frame_rx #(.CMD_ID(8'hFE), .NUM_PARAMS(NP), .ADDR_W(2), .DIV_W(16),
                        .MSB_FIRST(1'b0), .CSUM_EN(1'b0), .TIMEOUT_BITS(20)) dut_plain (
        .clk(clk), .reset(reset), .rx(rx_w[0]), .clk_per_bit(clk_per_bit),
        .wr_en(wr_en_w[0]), .wr_addr(wr_addr_w[0]), .wr_data(wr_data_w[0]),
        .busy(busy_w[0]), .frame_done(frame_done_w[0]), .frame_err(frame_err_w[0]),
        .err_code(err_code_w[0]));

    uart_cmd_frame_rx #(.CMD_ID(8'hFE), .NUM_PARAMS(NP), .ADDR_W(2), .DIV_W(16),
                        .MSB_FIRST(1'b0), .CSUM_EN(1'b1), .TIMEOUT_BITS(20)) dut_csum (
        .clk(clk), .reset(reset), .rx(rx_w[1]), .clk_per_bit(clk_per_bit),
        .wr_en(wr_en_w[1]), .wr_addr(wr_addr_w[1]), .wr_data(wr_data_w[1]),
        .busy(busy_w[1]), .frame_done(frame_done_w[1]), .frame_err(frame_err_w[1]),
        .err_code(err_code_w[1]));

    uart_cmd_frame_rx #(.CMD_ID(8'hFE), .NUM_PARAMS(NP), .ADDR_W(2), .DIV_W(16),
                        .MSB_FIRST(1'b1), .CSUM_EN(1'b0), .TIMEOUT_BITS(20)) dut_msb (
        .clk(clk), .reset(reset), .rx(rx_w[2]), .clk_per_bit(clk_per_bit),
        .wr_en(wr_en_w[2]), .wr_addr(wr_addr_w[2]), .wr_data(wr_data_w[2]),
        .busy(busy_w[2]), .frame_done(frame_done_w[2]), .frame_err(frame_err_w[2]),
        .err_code(err_code_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Value the DUT sees for a byte sent LSB-first on the line.
    function automatic logic [7:0] view(input int d, input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return (d == 2) ? r : b;
    endfunction

    function automatic bit take(input int d, output ev_t e);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].dut == d) begin
                e = exp_q[i];
                exp_q.delete(i);
                return 1'b1;
            end
        end
        e = '{default: 0};
        return 1'b0;
    endfunction

    // Frame rules applied one received byte at a time.
    task automatic model_byte(input int d, input logic [7:0] line, input bit stop_ok);
        logic [7:0] v;
        v = view(d, line);
        if (!m_in[d]) begin
            if (stop_ok && v == 8'hFE) begin
                m_in[d] = 1; m_csum[d] = 0; m_idx[d] = 0; m_sum[d] = 0; m_err[d] = 0;
            end
        end else if (!stop_ok) begin
            exp_q.push_back('{dut: d, kind: K_ERR, addr: 0, data: 0, code: 1, same: 0});
            m_in[d] = 0; m_err[d] = 1;
        end else if (m_csum[d]) begin
            if (v == m_sum[d]) begin
                exp_q.push_back('{dut: d, kind: K_DONE, addr: 0, data: 0, code: 0, same: 0});
            end else begin
                exp_q.push_back('{dut: d, kind: K_ERR, addr: 0, data: 0, code: 3, same: 0});
                m_err[d] = 3;
            end
            m_in[d] = 0;
        end else begin
            exp_q.push_back('{dut: d, kind: K_WR, addr: m_idx[d], data: int'(v), code: 0, same: 0});
            m_sum[d] = m_sum[d] + v;
            m_idx[d]++;
            if (m_idx[d] == NP) begin
                if (d == 1) begin
                    m_csum[d] = 1;
                end else begin
                    exp_q.push_back('{dut: d, kind: K_DONE, addr: 0, data: 0, code: 0, same: 1});
                    m_in[d] = 0;
                end
            end
        end
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input bit stop_ok, input int gap_bits);
        $display("[%0t] dut%0d tx %02h stop=%0d cpb=%0d", $time, d, b, stop_ok, cpb);
        model_byte(d, b, stop_ok);
        rx_w[d] = 1'b0;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            rx_w[d] = b[i];
            tick(cpb);
        end
        rx_w[d] = stop_ok;
        tick(cpb);
        rx_w[d] = 1'b1;
        tick(2);
        check("busy_after_byte", 32'(busy_w[d]), 32'(m_in[d]));
        check("err_code_held", 32'(err_code_w[d]), 32'(m_err[d]));
        tick(stop_ok ? gap_bits * cpb : 12 * cpb);
    endtask

    task automatic random_frame(input int d);
        logic [7:0] b;
        logic [7:0] s;
        int n_junk;
        cpb = $urandom_range(10, 24);
        clk_per_bit = 16'(cpb);
        n_junk = $urandom_range(0, 2);
        for (int j = 0; j < n_junk; j++) begin
            b = 8'($urandom);
            if (view(d, b) == 8'hFE) b = b ^ 8'h01;
            send_byte(d, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        send_byte(d, (d == 2) ? 8'h7F : 8'hFE, 1'b1, $urandom_range(0, 2));
        s = 8'h00;
        for (int j = 0; j < NP; j++) begin
            b = 8'($urandom);
            s = s + b;
            send_byte(d, b, 1'b1, $urandom_range(0, 2));
        end
        if (d == 1) begin
            if ($urandom_range(0, 1) == 1) s = s + 8'($urandom_range(1, 255));
            send_byte(d, s, 1'b1, 1);
        end
        cpb = 16;
        clk_per_bit = 16'(cpb);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, 32'({wr_en_w, frame_done_w, frame_err_w, busy_w}), 32'd0);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_addr"}, 32'(wr_addr_w[d]), 32'd0);
            check({tag, "_data"}, 32'(wr_data_w[d]), 32'd0);
            check({tag, "_code"}, 32'(err_code_w[d]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  found;
        for (int d = 0; d < 3; d++) begin
            if (wr_en_w[d] === 1'b1) begin
                found = take(d, e);
                check("wr_expected", 32'(found), 32'd1);
                if (found) begin
                    check("wr_kind", 32'(e.kind), 32'(K_WR));
                    check("wr_addr", 32'(wr_addr_w[d]), 32'(e.addr));
                    check("wr_data", 32'(wr_data_w[d]), 32'(e.data));
                end
            end
            if (frame_done_w[d] === 1'b1) begin
                found = take(d, e);
                check("done_expected", 32'(found), 32'd1);
                if (found) begin
                    check("done_kind", 32'(e.kind), 32'(K_DONE));
                    check("done_with_wr", 32'(wr_en_w[d]), 32'(e.same));
                end
            end
            if (frame_err_w[d] === 1'b1) begin
                found = take(d, e);
                check("err_expected", 32'(found), 32'd1);
                if (found) begin
                    check("err_kind", 32'(e.kind), 32'(K_ERR));
                    check("err_code", 32'(err_code_w[d]), 32'(e.code));
                    check("err_busy_low", 32'(busy_w[d]), 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[4];
        reset = 1'b1;
        rx_w = 3'b111;
        clk_per_bit = 16'(cpb);
        for (int d = 0; d < 3; d++) begin
            m_in[d] = 0; m_csum[d] = 0; m_idx[d] = 0; m_sum[d] = 0; m_err[d] = 0;
        end
        tick(4);
        check_all_zero("reset_state");
        reset = 1'b0;
        tick(4);

        // Nominal back-to-back frame
        send_byte(0, 8'hFE, 1'b1, 0);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_byte(0, pl[i], 1'b1, 0);
        tick(2 * cpb);
        check("addr_held", 32'(wr_addr_w[0]), 32'd3);
        check("data_held", 32'(wr_data_w[0]), 32'h44);

        // Hunt filtering, glitch rejection, CMD_ID as payload
        send_byte(0, 8'h00, 1'b1, 1);
        send_byte(0, 8'hA5, 1'b1, 1);
        rx_w[0] = 1'b0;
        tick(3);
        rx_w[0] = 1'b1;
        tick(2 * cpb);
        check("glitch_idle_busy", 32'(busy_w[0]), 32'd0);
        send_byte(0, 8'hFE, 1'b1, 0);
        pl = '{8'h01, 8'hFE, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) send_byte(0, pl[i], 1'b1, 1);

        // Checksum good then bad
        for (int r = 0; r < 2; r++) begin
            send_byte(1, 8'hFE, 1'b1, 0);
            for (int i = 1; i <= 4; i++) send_byte(1, 8'(i), 1'b1, 0);
            send_byte(1, (r == 0) ? 8'h0A : 8'h0B, 1'b1, 2);
        end

        // Framing error, then a normal frame
        send_byte(0, 8'hFE, 1'b1, 0);
        send_byte(0, 8'h01, 1'b1, 0);
        send_byte(0, 8'h55, 1'b0, 0);
        send_byte(0, 8'hFE, 1'b1, 0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1, 0);

        // Inter-byte timeout: quiet just short of the limit, then past it
        send_byte(0, 8'hFE, 1'b1, 0);
        send_byte(0, 8'h01, 1'b1, 0);
        tick(18 * cpb);
        check("no_early_timeout", 32'(busy_w[0]), 32'd1);
        exp_q.push_back('{dut: 0, kind: K_ERR, addr: 0, data: 0, code: 2, same: 0});
        m_in[0] = 0; m_err[0] = 2;
        tick(10 * cpb);
        check("timeout_busy", 32'(busy_w[0]), 32'd0);
        check("timeout_code", 32'(err_code_w[0]), 32'd2);

        // MSB-first: line 7F is CMD_ID FE
        send_byte(2, 8'h7F, 1'b1, 0);
        for (int i = 0; i < 4; i++) send_byte(2, 8'($urandom), 1'b1, 0);

        for (int k = 0; k < 6; k++) random_frame(k % 3);

        // Reset in the middle of a payload byte
        send_byte(0, 8'hFE, 1'b1, 0);
        send_byte(0, 8'h5A, 1'b1, 0);
        send_byte(0, 8'hC3, 1'b1, 0);
        rx_w[0] = 1'b0;
        tick(cpb);
        rx_w[0] = 1'b1;
        tick(3 * cpb);
        check("pending_before_reset", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        tick(1);
        check_all_zero("mid_byte_reset");
        reset = 1'b0;
        rx_w = 3'b111;
        for (int d = 0; d < 3; d++) begin
            m_in[d] = 0; m_csum[d] = 0; m_idx[d] = 0; m_sum[d] = 0; m_err[d] = 0;
        end
        tick(12 * cpb);
        send_byte(0, 8'hFE, 1'b1, 0);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom), 1'b1, 0);
        tick(4 * cpb);

        check("expected_events_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
